// File: rtl/goe.sv
// goe -- global output engine.
// Takes the packet word stream coming out of ebm and steers each packet to
// output port 0, port 1 or both. The head word's outport bitmap picks the
// ports. Packets with no destination are dropped. Packets whose destination
// is almost-full when the head arrives are also dropped. Forwarding is
// cut-through with one register stage and no packet buffer.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_goe_data/_data_wr            134-bit word + strobe ([133:132] 01 head, 11 body, 10 tail)
//   in_goe_valid/_valid_wr          packet-good flag + end-of-packet strobe (with tail)
//   out_goe_alf                     combinational OR of the two port almost-fulls
//   out_goe_data{0,1}/_data_wr{0,1} per-port word + strobe (registered)
//   out_goe_valid{0,1}/_valid_wr{0,1} per-port packet-good flag + end-of-packet strobe
//   in_goe_port{0,1}_alf            per-port almost-full
//   goe_*_cnt                       wrapping statistics counters read by lcm
module goe #(
  parameter int OUTPORT_LSB = 120,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [133:0]     in_goe_data,
  input  logic             in_goe_data_wr,
  input  logic             in_goe_valid,
  input  logic             in_goe_valid_wr,
  output logic             out_goe_alf,
  output logic [133:0]     out_goe_data0,
  output logic [133:0]     out_goe_data1,
  output logic             out_goe_data_wr0,
  output logic             out_goe_data_wr1,
  output logic             out_goe_valid0,
  output logic             out_goe_valid1,
  output logic             out_goe_valid_wr0,
  output logic             out_goe_valid_wr1,
  input  logic             in_goe_port0_alf,
  input  logic             in_goe_port1_alf,
  output logic [CNT_W-1:0] goe_pktin_cnt,
  output logic [CNT_W-1:0] goe_port0out_cnt,
  output logic [CNT_W-1:0] goe_port1out_cnt,
  output logic [CNT_W-1:0] goe_discard_cnt
);
  typedef enum logic [1:0] {IDLE, FWD, DISC} state_t;

  state_t     state;
  logic [1:0] dst;
  logic [1:0] bm, alf;
  logic       is_head, is_tail;
  logic       good;

  assign bm          = in_goe_data[OUTPORT_LSB+1:OUTPORT_LSB];
  assign alf         = {in_goe_port1_alf, in_goe_port0_alf};
  assign out_goe_alf = |alf;
  assign is_head     = in_goe_data_wr && (in_goe_data[133:132] == 2'b01);
  assign is_tail     = in_goe_data_wr && (in_goe_data[133:132] == 2'b10);
  // A tail without its end-of-packet strobe is closed as an abort (valid=0).
  assign good        = in_goe_valid && in_goe_valid_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      dst               <= 2'b00;
      out_goe_data0     <= '0;
      out_goe_data1     <= '0;
      out_goe_data_wr0  <= 1'b0;
      out_goe_data_wr1  <= 1'b0;
      out_goe_valid0    <= 1'b0;
      out_goe_valid1    <= 1'b0;
      out_goe_valid_wr0 <= 1'b0;
      out_goe_valid_wr1 <= 1'b0;
      goe_pktin_cnt     <= '0;
      goe_port0out_cnt  <= '0;
      goe_port1out_cnt  <= '0;
      goe_discard_cnt   <= '0;
    end else begin
      out_goe_data_wr0  <= 1'b0;
      out_goe_data_wr1  <= 1'b0;
      out_goe_valid0    <= 1'b0;
      out_goe_valid1    <= 1'b0;
      out_goe_valid_wr0 <= 1'b0;
      out_goe_valid_wr1 <= 1'b0;

      // Every head is counted as accepted, whatever happens to it afterwards.
      if (is_head) goe_pktin_cnt <= goe_pktin_cnt + CNT_W'(1);

      if (in_goe_data_wr) begin
        case (state)
          IDLE: begin
            if (is_head) begin
              // Multicast is all-or-nothing: any selected port almost-full drops it.
              if (bm == 2'b00 || (bm & ~alf) != bm) begin
                state           <= DISC;
                goe_discard_cnt <= goe_discard_cnt + CNT_W'(1);
              end else begin
                dst   <= bm;
                state <= FWD;
                if (bm[0]) begin out_goe_data_wr0 <= 1'b1; out_goe_data0 <= in_goe_data; end
                if (bm[1]) begin out_goe_data_wr1 <= 1'b1; out_goe_data1 <= in_goe_data; end
              end
            end
          end
          FWD: begin
            if (is_head) begin
              // Close the open packet with a bad end-of-packet and drop the new head.
              out_goe_valid_wr0 <= dst[0];
              out_goe_valid_wr1 <= dst[1];
              goe_discard_cnt   <= goe_discard_cnt + CNT_W'(1);
              state             <= DISC;
            end else begin
              if (dst[0]) begin out_goe_data_wr0 <= 1'b1; out_goe_data0 <= in_goe_data; end
              if (dst[1]) begin out_goe_data_wr1 <= 1'b1; out_goe_data1 <= in_goe_data; end
              if (is_tail) begin
                out_goe_valid_wr0 <= dst[0];
                out_goe_valid_wr1 <= dst[1];
                out_goe_valid0    <= dst[0] & good;
                out_goe_valid1    <= dst[1] & good;
                if (dst[0]) goe_port0out_cnt <= goe_port0out_cnt + CNT_W'(1);
                if (dst[1]) goe_port1out_cnt <= goe_port1out_cnt + CNT_W'(1);
                state <= IDLE;
              end
            end
          end
          DISC: begin
            if (is_head)      goe_discard_cnt <= goe_discard_cnt + CNT_W'(1);
            else if (is_tail) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_goe.sv
module tb_goe;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [133:0]  in_goe_data = '0;
  logic          in_goe_data_wr = 1'b0, in_goe_valid = 1'b0, in_goe_valid_wr = 1'b0;
  logic          in_goe_port0_alf = 1'b0, in_goe_port1_alf = 1'b0;
  logic          out_goe_alf;
  logic [133:0]  out_goe_data0, out_goe_data1;
  logic          out_goe_data_wr0, out_goe_data_wr1, out_goe_valid0, out_goe_valid1;
  logic          out_goe_valid_wr0, out_goe_valid_wr1;
  logic [CW-1:0] goe_pktin_cnt, goe_port0out_cnt, goe_port1out_cnt, goe_discard_cnt;

  goe #(.OUTPORT_LSB(120), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_goe_data(in_goe_data), .in_goe_data_wr(in_goe_data_wr),
    .in_goe_valid(in_goe_valid), .in_goe_valid_wr(in_goe_valid_wr),
    .out_goe_alf(out_goe_alf),
    .out_goe_data0(out_goe_data0), .out_goe_data1(out_goe_data1),
    .out_goe_data_wr0(out_goe_data_wr0), .out_goe_data_wr1(out_goe_data_wr1),
    .out_goe_valid0(out_goe_valid0), .out_goe_valid1(out_goe_valid1),
    .out_goe_valid_wr0(out_goe_valid_wr0), .out_goe_valid_wr1(out_goe_valid_wr1),
    .in_goe_port0_alf(in_goe_port0_alf), .in_goe_port1_alf(in_goe_port1_alf),
    .goe_pktin_cnt(goe_pktin_cnt), .goe_port0out_cnt(goe_port0out_cnt),
    .goe_port1out_cnt(goe_port1out_cnt), .goe_discard_cnt(goe_discard_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: packet-level bookkeeping. "open_ports" is the set of
  // ports currently carrying a packet; "dropping" means we are skipping the
  // rest of a rejected packet.
  logic [1:0]    open_ports;
  bit            dropping;
  logic [1:0]    e_wr, e_vwr, e_v;
  logic [133:0]  e_d0, e_d1;
  logic [CW-1:0] e_pktin, e_p0, e_p1, e_disc;

  localparam logic [1:0] HEAD = 2'b01, BODY = 2'b11, TAIL = 2'b10;

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":wr0"}, out_goe_data_wr0, e_wr[0]);
    chk({tag, ":wr1"}, out_goe_data_wr1, e_wr[1]);
    chk({tag, ":vwr0"}, out_goe_valid_wr0, e_vwr[0]);
    chk({tag, ":vwr1"}, out_goe_valid_wr1, e_vwr[1]);
    chk({tag, ":v0"}, out_goe_valid0, e_v[0]);
    chk({tag, ":v1"}, out_goe_valid1, e_v[1]);
    chk({tag, ":d0"}, out_goe_data0, e_d0);
    chk({tag, ":d1"}, out_goe_data1, e_d1);
    chk({tag, ":pktin"}, goe_pktin_cnt, e_pktin);
    chk({tag, ":p0out"}, goe_port0out_cnt, e_p0);
    chk({tag, ":p1out"}, goe_port1out_cnt, e_p1);
    chk({tag, ":disc"}, goe_discard_cnt, e_disc);
    chk({tag, ":alf"}, out_goe_alf, in_goe_port0_alf | in_goe_port1_alf);
  endtask

  task automatic model_reset();
    open_ports = 2'b00; dropping = 0;
    e_wr = 0; e_vwr = 0; e_v = 0; e_d0 = '0; e_d1 = '0;
    e_pktin = 0; e_p0 = 0; e_p1 = 0; e_disc = 0;
  endtask

  // Expected outputs one cycle after the presented input word.
  task automatic model_step();
    logic [1:0] bm, alfv;
    e_wr = 0; e_vwr = 0; e_v = 0;
    if (!in_goe_data_wr) return;
    bm   = in_goe_data[121:120];
    alfv = {in_goe_port1_alf, in_goe_port0_alf};
    case (in_goe_data[133:132])
      HEAD: begin
        e_pktin++;
        if (open_ports != 0) begin
          e_vwr = open_ports; open_ports = 0; dropping = 1; e_disc++;
        end else if (dropping) begin
          e_disc++;
        end else if (bm == 0 || (bm & alfv) != 0) begin
          dropping = 1; e_disc++;
        end else begin
          open_ports = bm; e_wr = bm;
        end
      end
      TAIL: begin
        if (open_ports != 0) begin
          e_wr = open_ports; e_vwr = open_ports;
          if (in_goe_valid_wr && in_goe_valid) e_v = open_ports;
          if (open_ports[0]) e_p0++;
          if (open_ports[1]) e_p1++;
          open_ports = 0;
        end
        dropping = 0;
      end
      default: if (open_ports != 0) e_wr = open_ports;
    endcase
    if (e_wr[0]) e_d0 = in_goe_data;
    if (e_wr[1]) e_d1 = in_goe_data;
  endtask

  function automatic logic [133:0] mkword(input logic [1:0] t, input logic [1:0] bm);
    logic [133:0] d;
    d[127:0]   = {$urandom, $urandom, $urandom, $urandom};
    d[131:128] = 4'($urandom);
    d[121:120] = bm;
    d[133:132] = t;
    return d;
  endfunction

  // Present one word (or an idle cycle when wr=0), then check a cycle later.
  task automatic step(input string tag, input bit wr, input logic [1:0] t, input logic [1:0] bm,
                      input bit v, input bit vwr, input bit a0, input bit a1);
    in_goe_data      = mkword(t, bm);
    in_goe_data_wr   = wr;
    in_goe_valid     = v;
    in_goe_valid_wr  = vwr;
    in_goe_port0_alf = a0;
    in_goe_port1_alf = a1;
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic pkt(input string tag, input logic [1:0] bm, input int nbody, input bit v,
                     input bit a0, input bit a1);
    step(tag, 1, HEAD, bm, 0, 0, a0, a1);
    for (int i = 0; i < nbody; i++) step(tag, 1, BODY, 2'b00, 0, 0, 0, 0);
    step(tag, 1, TAIL, 2'b00, v, 1, 0, 0);
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("idle");

    pkt("uni_p0", 2'b01, 2, 1, 0, 0);
    chk("uni_p0_done", {goe_pktin_cnt, goe_port0out_cnt, goe_port1out_cnt}, {4'd1, 4'd1, 4'd0});
    pkt("mc_bad", 2'b11, 1, 0, 0, 0);
    pkt("mc_alf", 2'b11, 1, 1, 0, 1);
    pkt("p1_only", 2'b10, 1, 1, 0, 0);
    // Back-to-back: tail followed immediately by head, with alf rising mid-packet.
    step("b2b", 1, HEAD, 2'b01, 0, 0, 0, 0);
    step("b2b", 1, BODY, 2'b00, 0, 0, 1, 1);
    step("b2b", 1, TAIL, 2'b00, 1, 1, 1, 0);
    pkt("b2b2", 2'b10, 0, 1, 0, 0);
    pkt("bm00", 2'b00, 1, 1, 0, 0);
    step("stray", 1, BODY, 2'b11, 0, 0, 0, 0);
    step("stray", 1, TAIL, 2'b11, 1, 1, 0, 0);
    // Tail without end-of-packet strobe closes as an abort.
    step("abort", 1, HEAD, 2'b11, 0, 0, 0, 0);
    step("abort", 1, TAIL, 2'b00, 1, 0, 0, 0);
    // Head during forwarding closes the old packet and drops the new one.
    step("dup_head", 1, HEAD, 2'b01, 0, 0, 0, 0);
    step("dup_head", 1, BODY, 2'b00, 0, 0, 0, 0);
    step("dup_head", 1, HEAD, 2'b01, 0, 0, 0, 0);
    step("dup_head", 1, HEAD, 2'b10, 0, 0, 0, 0);
    step("dup_head", 1, TAIL, 2'b00, 1, 1, 0, 0);
    step("gap", 0, BODY, 2'b01, 0, 0, 0, 0);

    // Reset in the middle of a 5-word packet.
    step("rst_mid", 1, HEAD, 2'b01, 0, 0, 0, 0);
    step("rst_mid", 1, BODY, 2'b00, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rst_tail", 1, BODY, 2'b00, 0, 0, 0, 0);
    step("rst_tail", 1, BODY, 2'b00, 0, 0, 0, 0);
    step("rst_tail", 1, TAIL, 2'b00, 1, 1, 0, 0);

    for (int i = 0; i < 17; i++) pkt("wrap", 2'b01, 1, 1, 0, 0);
    chk("wrap_p0out", goe_port0out_cnt, 4'd1);

    // Randomized word stream.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] t;
      bit         tail;
      t = 2'($urandom_range(1, 3));
      tail = (t == TAIL);
      step("rand", ($urandom_range(0, 9) < 8), t, 2'($urandom),
           1'($urandom), tail && ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
